serial_add_nbit: RTL
====================

// Module: serial_add_nbit
// PURPOSE
//   Bit-serial ripple adder, one sum bit per clock. Sits downstream of the 2-input gate
//   primitives: the per-bit generate/propagate uses a_bit & b_bit and a_bit ^ b_bit.
//   A start pulse loads two WIDTH-bit operands and a carry-in. The block then emits a
//   registered WIDTH-bit sum and carry-out with a one-cycle done pulse.
// PARAMETERS
//   WIDTH   2   operand/sum width in bits; legal range 1..16
// PORTS
//   clk_in     in   1      clock, all state updates on rising edge
//   rst_in     in   1      reset, asynchronous, active-high
//   start_in   in   1      request; accepted only when ready_out=1
//   clear_in   in   1      synchronous abort of an in-flight add
//   a_in       in   WIDTH  operand A, sampled on accepted start
//   b_in       in   WIDTH  operand B, sampled on accepted start
//   c_in       in   1      carry-in, sampled on accepted start
//   ready_out  out  1      1 only in IDLE
//   busy_out   out  1      1 in RUN
//   done_out   out  1      single-cycle pulse, result valid
//   sum_out    out  WIDTH  registered sum, held until the next accepted start
//   carry_out  out  1      registered carry-out, held with sum_out
// BEHAVIOUR
//   Reset (rst_in=1, async): state=IDLE, bit counter=0, carry reg=0.
//     Outputs during and after reset: ready_out=1, busy_out=0, done_out=0, sum_out=0, carry_out=0.
//   States:
//     IDLE -> RUN   when start_in=1. Load shift regs from a_in/b_in, carry reg from c_in, cnt=0.
//                   Clear sum_out and carry_out to 0.
//     RUN           each edge processes bit cnt (LSB first):
//                     s = a^b^c, c' = (a&b)|(c&(a^b)); write s into sum_out[cnt]; cnt++.
//     RUN -> DONE   on the edge that processes bit WIDTH-1; carry_out <= final c'.
//     DONE -> IDLE  unconditionally after one cycle; done_out=1 only while in DONE.
//   Latency: start accepted at edge k. done_out is high in the cycle after edge k+WIDTH.
//     Next start is accepted no earlier than edge k+WIDTH+2.
//   start_in is ignored in RUN and DONE. It is not queued, and operand inputs are don't-care.
//   clear_in=1 in RUN: go to IDLE next edge; no done pulse; sum_out/carry_out hold partial value.
//   clear_in has priority over start_in in IDLE (no accept). It has no effect in DONE.
//   Arithmetic is unsigned: {carry_out,sum_out} = a_in + b_in + c_in exactly, with no overflow loss.
//   rst_in asserted mid-RUN: immediate return to reset values. The in-flight result is discarded.
//   Counter width is clog2(WIDTH)+1; no wrap occurs because DONE is entered at cnt=WIDTH-1.
// TESTING
//   1. WIDTH=2, reset, then start a=3 b=1 c=0 -> done after 2 RUN cycles; sum_out=00, carry_out=1.
//   2. WIDTH=2, a=3 b=3 c=1 -> sum_out=11, carry_out=1. Also a=0 b=0 c=0 -> 00/0 with done pulse.
//   3. WIDTH=2, start a=1 b=1, then pulse start with a=3 b=3 during RUN -> ignored; result 10/0.
//      done_out is high exactly one cycle.
//   4. WIDTH=2, rst_in high mid-RUN, asynchronously between edges -> all outputs go to reset values
//      without waiting for a clock; no done pulse.
//   5. clear_in in RUN -> ready_out=1 next cycle, no done. start+clear together in IDLE -> no accept.
//   6. WIDTH=4, back-to-back starts at earliest legal edge: 9+8+0 -> 0001/1, then 15+15+1 -> 1111/1.

Source files
------------

// File: rtl/serial_add_nbit.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_nbit
// Purpose  : Bit-serial ripple adder. A start pulse loads two WIDTH-bit
//            operands plus a carry-in. One sum bit is produced per clock,
//            LSB first. A single-cycle done pulse marks the registered
//            {carry_out, sum_out} result.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_nbit #(
  parameter int WIDTH = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             clear_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             ready_out,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  // One extra counter bit so the post-increment value WIDTH never wraps.
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;

  logic             a_bit;
  logic             b_bit;
  logic             gen;
  logic             prop;
  logic             sum_bit;
  logic             carry_next;
  logic             last_bit;
  logic [WIDTH-1:0] bit_sel;

  // Per-bit generate/propagate, built from plain 2-input gates.
  assign a_bit      = a_sh[0];
  assign b_bit      = b_sh[0];
  assign gen        = a_bit & b_bit;
  assign prop       = a_bit ^ b_bit;
  assign sum_bit    = prop ^ carry;
  assign carry_next = gen | (carry & prop);
  assign last_bit   = (cnt == CNT_W'(WIDTH - 1));

  // One-hot select of the sum position being written this cycle.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit_sel
      assign bit_sel[i] = (cnt == CNT_W'(i));
    end
  endgenerate

  // Control FSM plus operand shift registers and sum/carry result registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_out   <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // clear_in wins over start_in so an abort never launches a new add.
          if (start_in && !clear_in) begin
            a_sh      <= a_in;
            b_sh      <= b_in;
            carry     <= c_in;
            cnt       <= '0;
            sum_out   <= '0;
            carry_out <= 1'b0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (clear_in) begin
            // Abort: partial sum_out/carry_out are left as they are.
            state <= ST_IDLE;
          end else begin
            sum_out <= (sum_out & ~bit_sel) | (bit_sel & {WIDTH{sum_bit}});
            carry   <= carry_next;
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            cnt     <= cnt + CNT_W'(1);
            if (last_bit) begin
              carry_out <= carry_next;
              state     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready_out = (state == ST_IDLE);
  assign busy_out  = (state == ST_RUN);
  assign done_out  = (state == ST_DONE);

endmodule
`default_nettype wire
